mesm6_alu_ctl: RTL and testbench

- Sequencer and two-port arbiter in front of mesm6_alu.
- Accepts ALU commands from two requesters: port 0 is the instruction execution unit, port 1 is the microcode/interrupt unit. Grants are round-robin.
- Drives the ALU op/operand/mode lines and holds them stable until alu_done.
- Forces the mandatory ALU_NOP cycle between operations and returns acc on a backpressured response channel.
- A watchdog turns never-completing ops (unimplemented FMUL/FDIV) into an error response.

---
 rtl/mesm6_alu_ctl.sv | 189 ++++++++++++++++++
 tb/tb_mesm6_alu_ctl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesm6_alu_ctl.sv
// mesm6_alu_ctl: two-port round-robin command sequencer in front of mesm6_alu.
// Holds ALU inputs until done, forces a NOP between ops and times out hung ops.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 6
`endif
`ifndef ALU_NOP
`define ALU_NOP 0
`endif

module mesm6_alu_ctl #(
    parameter int unsigned OP_W    = `ALU_OP_WIDTH,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OP_W-1:0] req0_op,
    input  logic [3:0]      req0_mode,
    input  logic [47:0]     req0_a,
    input  logic [47:0]     req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OP_W-1:0] req1_op,
    input  logic [3:0]      req1_mode,
    input  logic [47:0]     req1_a,
    input  logic [47:0]     req1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [47:0]     rsp_acc,
    output logic            rsp_err,
    output logic [OP_W-1:0] alu_op,
    output logic            alu_wy,
    output logic            alu_grp_log,
    output logic            alu_do_norm,
    output logic            alu_do_round,
    output logic [47:0]     alu_a,
    output logic [47:0]     alu_b,
    input  logic [47:0]     alu_acc,
    input  logic            alu_done,
    output logic            busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWy   = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    localparam logic [OP_W-1:0] OpNop    = OP_W'(`ALU_NOP);
    localparam logic [15:0]     WdogLast = 16'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [15:0]     wdog_q, wdog_d;
    logic [OP_W-1:0] alu_op_q, alu_op_d;
    logic [3:0]      mode_q, mode_d;
    logic [47:0]     alu_a_q, alu_a_d;
    logic [47:0]     alu_b_q, alu_b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [47:0]     rsp_acc_q, rsp_acc_d;
    logic            rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;

    logic            grant1;
    logic            accept;
    logic [OP_W-1:0] sel_op;

    // Port 1 wins when it is alone, or when both ask and port 0 was served last.
    always_comb begin
        grant1 = req1_valid && (!req0_valid || !last_grant_q);
        accept = (state_q == StIdle) && (req0_valid || req1_valid);
        sel_op = grant1 ? req1_op : req0_op;
    end

    assign req0_ready = accept && !grant1;
    assign req1_ready = accept && grant1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wdog_d       = wdog_q;
        alu_op_d     = alu_op_q;
        mode_d       = mode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_acc_d    = rsp_acc_q;
        rsp_err_d    = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    alu_op_d     = sel_op;
                    mode_d       = grant1 ? req1_mode : req0_mode;
                    alu_a_d      = grant1 ? req1_a : req0_a;
                    alu_b_d      = grant1 ? req1_b : req0_b;
                    last_grant_d = grant1;
                    rsp_id_d     = grant1;
                    wdog_d       = '0;
                    state_d      = (sel_op == OpNop) ? StWy : StRun;
                end
            end
            StWy: begin
                // alu_wy was high for exactly this NOP cycle, so Y now holds A.
                mode_d[3]   = 1'b0;
                rsp_acc_d   = alu_a_q;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StRun: begin
                if (wdog_q != 16'hffff) begin
                    wdog_d = wdog_q + 16'd1;
                end
                if (alu_done) begin
                    rsp_acc_d   = alu_acc;
                    rsp_err_d   = 1'b0;
                    alu_op_d    = OpNop;
                    mode_d[3]   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else if (wdog_q == WdogLast) begin
                    rsp_acc_d   = '0;
                    rsp_err_d   = 1'b1;
                    alu_op_d    = OpNop;
                    mode_d[3]   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            wdog_q       <= '0;
            alu_op_q     <= OpNop;
            mode_q       <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_acc_q    <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            alu_op_q     <= alu_op_d;
            mode_q       <= mode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_acc_q    <= rsp_acc_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_op       = alu_op_q;
    assign alu_wy       = mode_q[3];
    assign alu_grp_log  = mode_q[2];
    assign alu_do_norm  = mode_q[1];
    assign alu_do_round = mode_q[0];
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_acc      = rsp_acc_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mesm6_alu_ctl.sv
// Bench for mesm6_alu_ctl: a stub ALU plus a transaction-level model that predicts
// grants, response contents and response timing from the arbitration/latency rules.
module tb_mesm6_alu_ctl;

    localparam int unsigned OpW     = 6;
    localparam int unsigned Timeout = 8;

    localparam logic [5:0] OpNop    = 6'd0;
    localparam logic [5:0] OpAnd    = 6'd1;
    localparam logic [5:0] OpXor    = 6'd2;
    localparam logic [5:0] OpAddCa  = 6'd3;
    localparam logic [5:0] OpFmul   = 6'd4;
    localparam logic [5:0] OpYta    = 6'd5;
    localparam logic [5:0] OpSlowOk = 6'd6;
    localparam logic [5:0] OpSlowTo = 6'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [5:0]  req0_op = '0, req1_op = '0;
    logic [3:0]  req0_mode = '0, req1_mode = '0;
    logic [47:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp_valid, rsp_id, rsp_err;
    logic        rsp_ready = 1'b1;
    logic [47:0] rsp_acc;
    logic [5:0]  alu_op;
    logic        alu_wy, alu_grp_log, alu_do_norm, alu_do_round;
    logic [47:0] alu_a, alu_b;
    logic [47:0] alu_acc = '0;
    logic        alu_done = 1'b0;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned cyc = 0;

    mesm6_alu_ctl #(
        .OP_W    (OpW),
        .TIMEOUT (Timeout)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_mode    (req0_mode),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_mode    (req1_mode),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_acc      (rsp_acc),
        .rsp_err      (rsp_err),
        .alu_op       (alu_op),
        .alu_wy       (alu_wy),
        .alu_grp_log  (alu_grp_log),
        .alu_do_norm  (alu_do_norm),
        .alu_do_round (alu_do_round),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_acc      (alu_acc),
        .alu_done     (alu_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Done-cycles per op of the stub ALU; 0 means it never finishes.
    function automatic int unsigned op_lat(input logic [5:0] op);
        case (op)
            OpAnd, OpXor, OpYta: return 1;
            OpAddCa:             return 2;
            OpSlowOk:            return Timeout - 1;
            OpSlowTo:            return Timeout;
            default:             return 0;
        endcase
    endfunction

    function automatic logic [47:0] op_res(input logic [5:0] op, input logic [47:0] a,
                                           input logic [47:0] b, input logic [47:0] y);
        logic [48:0] s;
        case (op)
            OpAnd:    return a & b;
            OpXor:    return a ^ b;
            OpAddCa: begin
                s = {1'b0, a} + {1'b0, b};
                return s[47:0] + {47'd0, s[48]};
            end
            OpYta:    return y;
            OpSlowOk: return a + b;
            default:  return a - b;
        endcase
    endfunction

    // Stub ALU: NOP clears done and may write Y; other ops finish after op_lat cycles.
    logic [47:0] f_y = '0;
    int unsigned f_cnt = 0;
    always @(posedge clk) begin
        if (alu_op == OpNop) begin
            alu_done <= 1'b0;
            f_cnt    <= 0;
            if (alu_wy) f_y <= alu_a;
        end else if (!alu_done) begin
            f_cnt <= f_cnt + 1;
            if (op_lat(alu_op) != 0 && f_cnt + 1 == op_lat(alu_op)) begin
                alu_done <= 1'b1;
                alu_acc  <= op_res(alu_op, alu_a, alu_b, f_y);
            end
        end
    end

    // Transaction model: one outstanding op, predicted response cycle and contents.
    logic        m_out = 1'b0, m_last = 1'b1;
    int unsigned m_t = 0, m_due = 0, k;
    logic [5:0]  m_op;
    logic [3:0]  m_mode;
    logic [47:0] m_a, m_b, m_acc;
    logic [47:0] m_y = '0;
    logic        m_id, m_err, exp_v, g;
    int          grant_q[$];
    int unsigned acc_cyc_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_out  = 1'b0;
            m_last = 1'b1;
        end else begin
            check("busy", busy, m_out);
            exp_v = m_out && (cyc >= m_due);
            check("rsp_valid", rsp_valid, exp_v);
            if (exp_v) begin
                check("rsp_id", rsp_id, m_id);
                check("rsp_acc", rsp_acc, m_acc);
                check("rsp_err", rsp_err, m_err);
                check("resp_alu_op", alu_op, OpNop);
            end
            if (m_out && cyc == m_t + 1) begin
                check("issue_alu_op", alu_op, m_op);
                if (m_op == OpNop) check("issue_wy", alu_wy, m_mode[3]);
                else begin
                    check("issue_a", alu_a, m_a);
                    check("issue_b", alu_b, m_b);
                end
            end
            if (req0_valid && req1_valid) g = !m_last;
            else g = req1_valid;
            check("req0_ready", req0_ready, !m_out && req0_valid && !g);
            check("req1_ready", req1_ready, !m_out && req1_valid && g);
            if (exp_v && rsp_ready) begin
                m_out = 1'b0;
            end else if (!m_out && (req0_valid || req1_valid)) begin
                m_op   = g ? req1_op : req0_op;
                m_mode = g ? req1_mode : req0_mode;
                m_a    = g ? req1_a : req0_a;
                m_b    = g ? req1_b : req0_b;
                m_id   = g;
                m_last = g;
                m_t    = cyc;
                grant_q.push_back(int'(g));
                acc_cyc_q.push_back(cyc);
                if (m_op == OpNop) begin
                    m_acc = m_a;
                    m_err = 1'b0;
                    m_due = cyc + 2;
                    if (m_mode[3]) m_y = m_a;
                end else begin
                    k = op_lat(m_op);
                    if (k == 0 || k >= Timeout) begin
                        m_acc = '0;
                        m_err = 1'b1;
                        m_due = cyc + Timeout + 1;
                    end else begin
                        m_acc = op_res(m_op, m_a, m_b, m_y);
                        m_err = 1'b0;
                        m_due = cyc + k + 2;
                    end
                end
                m_out = 1'b1;
            end
        end
    end

    task automatic send(input int port, input logic [5:0] op, input logic [3:0] mode,
                        input logic [47:0] a, input logic [47:0] b);
        logic ok = 1'b0;
        if (port == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_mode = mode; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_mode = mode; req1_a = a; req1_b = b;
        end
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            ok = (port == 0) ? req0_ready : req1_ready;
        end
        check("accept", ok, 1);
        @(posedge clk);
        #1;
        if (port == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic id, output logic [47:0] acc, output logic err);
        logic ok = 1'b0;
        id = 1'b0; acc = '0; err = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                id = rsp_id; acc = rsp_acc; err = rsp_err; ok = 1'b1;
                break;
            end
        end
        check("rsp_wait", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_drv(input int port, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(port, 6'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 48'({$urandom, $urandom}), 48'({$urandom, $urandom}));
        end
    endtask

    logic        r_id, r_err, rand_on;
    logic [47:0] r_acc;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_alu_op", alu_op, OpNop);
        check("rst_alu_mode", {alu_wy, alu_grp_log, alu_do_norm, alu_do_round}, 4'd0);
        check("rst_alu_a", alu_a, 48'd0);
        check("rst_alu_b", alu_b, 48'd0);
        check("rst_rsp", {rsp_valid, rsp_id, rsp_err}, 3'd0);
        check("rst_rsp_acc", rsp_acc, 48'd0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Single AND from port 0
        send(0, OpAnd, 4'd0, 48'hFFFF_0000_FFFF, 48'h0F0F_0F0F_0F0F);
        wait_rsp(r_id, r_acc, r_err);
        check("and_acc", r_acc, 48'h0F0F_0000_0F0F);
        check("and_id", r_id, 0);
        check("and_err", r_err, 0);

        // Both ports contending straight out of reset
        do_reset();
        grant_q.delete();
        acc_cyc_q.delete();
        fork
            begin
                send(0, OpXor, 4'd0, 48'h1111, 48'h0101);
                send(0, OpXor, 4'd0, 48'h2222, 48'h0202);
            end
            begin
                send(1, OpXor, 4'd0, 48'h3333, 48'h0303);
                send(1, OpXor, 4'd0, 48'h4444, 48'h0404);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("grant_count", grant_q.size(), 4);
        for (int i = 0; i < grant_q.size(); i++) check("grant_order", grant_q[i], i % 2);
        for (int i = 1; i < acc_cyc_q.size(); i++)
            check("accept_spacing", acc_cyc_q[i] - acc_cyc_q[i-1], 4);

        // Two-cycle end-around-carry add from port 1
        send(1, OpAddCa, 4'd0, 48'hFFFF_FFFF_FFFF, 48'h1);
        wait_rsp(r_id, r_acc, r_err);
        check("addca_acc", r_acc, 48'h1);
        check("addca_id", r_id, 1);

        // Never-finishing FMUL times out, next op is normal
        send(0, OpFmul, 4'd0, 48'h5, 48'h6);
        wait_rsp(r_id, r_acc, r_err);
        check("fmul_err", r_err, 1);
        check("fmul_acc", r_acc, 48'd0);
        send(0, OpAnd, 4'd0, 48'hF0F0, 48'hFF00);
        wait_rsp(r_id, r_acc, r_err);
        check("post_to_err", r_err, 0);
        check("post_to_acc", r_acc, 48'hF000);

        // Y write via NOP, then read back with YTA
        send(0, OpNop, 4'b1000, 48'h1234, 48'h0);
        check("wy_pulse_on", alu_wy, 1);
        check("wy_pulse_op", alu_op, OpNop);
        @(posedge clk);
        #1;
        check("wy_pulse_off", alu_wy, 0);
        wait_rsp(r_id, r_acc, r_err);
        check("wy_acc", r_acc, 48'h1234);
        send(0, OpYta, 4'b0100, 48'h0, 48'h0);
        wait_rsp(r_id, r_acc, r_err);
        check("yta_acc", r_acc, 48'h1234);

        // Response backpressure with a competing request
        rsp_ready = 1'b0;
        send(0, OpAnd, 4'd0, 48'hAAAA_5555_F0F0, 48'h0FF0_0FF0_FFFF);
        fork
            send(1, OpXor, 4'd0, 48'h00FF, 48'h0F0F);
        join_none
        for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_acc", rsp_acc, 48'h0AA0_0550_F0F0);
            check("bp_ready1", req1_ready, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_rsp(r_id, r_acc, r_err);
        check("bp_rsp_id", r_id, 0);
        wait_rsp(r_id, r_acc, r_err);
        check("bp_next_id", r_id, 1);
        check("bp_next_acc", r_acc, 48'h0FF0);

        // Reset in the middle of RUN
        send(0, OpFmul, 4'd0, 48'h7, 48'h8);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_alu_op", alu_op, OpNop);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Randomized traffic on both ports with random response backpressure
        rand_on = 1'b1;
        fork
            begin
                fork
                    rand_drv(0, 30);
                    rand_drv(1, 30);
                join
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        repeat (20) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
